axis_demux_4: RTL
=================

# axis_demux_4

AXI4-Stream 1-to-4 frame demultiplexer: the fan-out counterpart of the 4-port arbitrated mux, splitting one stream back onto four destinations. A destination is chosen once per frame from the `select` control input and held until `tlast`. A frame can also be dropped whole. Outputs are registered through a skid stage, so the block sustains one beat per cycle.

## Interface
- `DATA_WIDTH`, 8, tdata width in bits.
- `USER_ENABLE`, 1, 1 = carry tuser; 0 = tuser outputs tied to 0.
- `USER_WIDTH`, 1, tuser width in bits.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `input_axis_tdata`  in  DATA_WIDTH  input data.
- `input_axis_tvalid`  in  1  input beat valid.
- `input_axis_tready`  out  1  input beat accept (registered).
- `input_axis_tlast`  in  1  last beat of frame.
- `input_axis_tuser`  in  USER_WIDTH  sideband, passed through unchanged.
- `output_N_axis_tdata`  out  DATA_WIDTH  per output, N = 0..3.
- `output_N_axis_tvalid`  out  1  per output.
- `output_N_axis_tready`  in  1  per output.
- `output_N_axis_tlast`  out  1  per output.
- `output_N_axis_tuser`  out  USER_WIDTH  per output.
- `enable`  in  1  permits a new frame to start.
- `drop`  in  1  sampled at frame start; 1 = discard the frame.
- `select`  in  2  destination index, sampled at frame start.

## Operation
- FSM state IDLE, waiting for a frame:
  - If `input_axis_tvalid && enable`, latch `select` into `sel_reg` and `drop` into `drop_reg`, then go to BUSY.
  - Otherwise stay in IDLE with `input_axis_tready` = 0.
- FSM state BUSY, frame in progress:
  - Each accepted beat goes to output `sel_reg`, or is discarded if `drop_reg` = 1.
  - When an accepted beat has `tlast` = 1, go to IDLE.
- `select`, `drop` and `enable` are ignored while in BUSY.
- A frame can never be split across outputs or interleaved with another frame.
- Only output `sel_reg` can assert tvalid; the other three hold tvalid = 0.
- Drop mode:
  - `input_axis_tready` follows the BUSY state and is 1 on every cycle, independent of any output tready.
  - No output asserts tvalid.
- Per-output skid stage: a main register plus a temp register (2 entries).
  - Output register loads from the input when it is empty or when `output_N_axis_tready` = 1.
  - Otherwise the beat goes to the temp register.
  - Temp drains into the main register first, so beat order is preserved.
- tdata, tlast and tuser travel unchanged; there is no width conversion.

## Timing
- Reset values:
  - All `output_N_axis_tvalid` = 0.
  - `input_axis_tready` = 0.
  - FSM = IDLE.
  - Skid registers empty; `sel_reg` = 0; `drop_reg` = 0.
  - Data, last and user outputs = 0.
- Frame start:
  - `tvalid` at cycle t in IDLE gives `input_axis_tready` = 1 at t+1.
  - The first beat is accepted at t+1 at the earliest.
- Latency: a beat accepted at cycle k appears on the output with tvalid at k+1.
- `input_axis_tready` is registered:
  - In BUSY it is 1 when the skid stage will have a free slot next cycle.
  - That is: the temp register is empty and either the output tready is high or the main register is empty or not loaded this cycle.
- Throughput:
  - With the output tready held high, 1 beat/cycle.
  - Exactly 1 idle input cycle between back-to-back frames (the IDLE re-arbitration cycle).
- The `tlast` beat is accepted at cycle k, so `input_axis_tready` = 0 at k+1.
- Output backpressure:
  - At most 2 beats are buffered.
  - tready drops the cycle after the temp register fills.
- Output tvalid, once set, holds with stable data until accepted (AXI rule).
- `enable` = 0 while IDLE with tvalid high: the block stalls with tready = 0 and latches nothing.
- Reset mid-frame:
  - All state and buffers clear on the next edge.
  - The partial frame is truncated without tlast; the upstream and downstream owners handle recovery.

## Structure
- Package `axis_demux_pkg` holds:
  - `NUM_OUTPUTS` = 4.
  - `SEL_WIDTH` = 2.
  - The FSM enum `demux_state_t` {IDLE, BUSY}.
- Sub-module `axis_demux_out_reg`: one 2-entry skid register.
  - Four instances, one per output.
  - Each is given a per-output `load` strobe and reports `ready_early`.
- The top level holds the FSM, `sel_reg`, `drop_reg` and the tready mux.

## Test plan
- Reset, then drive a 4-beat frame with `select`=2 and data 0x10..0x13, tlast on 0x13, all outputs ready:
  - Output 2 shows 0x10..0x13 on consecutive cycles with tlast on 0x13.
  - Outputs 0, 1 and 3 keep tvalid at 0.
- Change `select` to 1 in the middle of a frame:
  - The remaining beats still go to output 2.
  - The next frame goes to output 1.
  - Exactly 1 idle input cycle between the two frames.
- Output 0 tready low for 5 cycles during a 6-beat frame:
  - `input_axis_tready` falls after 2 beats are buffered.
  - No beat is lost or reordered; the output matches the input sequence exactly.
- `drop`=1 at frame start on a 3-beat frame, with all output treadys held at 0:
  - Input accepts 3 beats on consecutive cycles.
  - No output tvalid asserts.
- `enable`=0 with tvalid high for 4 cycles:
  - tready stays 0.
  - After `enable` rises, the frame is routed normally.
- Assert `rst` on beat 2 of a frame:
  - The next cycle has every tvalid = 0, `input_axis_tready` = 0 and FSM = IDLE.
  - A new frame after reset routes correctly.

Source files
------------

// File: rtl/axis_demux_pkg.sv
// Shared constants and FSM state type for the 1-to-4 AXI4-Stream demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_demux_pkg;

  localparam int NUM_OUTPUTS = 4;
  localparam int SEL_WIDTH   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } demux_state_t;

endpackage

// File: rtl/axis_demux_if.sv
// AXI4-Stream bundle: tdata/tvalid/tready/tlast/tuser, one instance per stream.
// Latency: n/a (wiring only).
// Backpressure: tready flows from slave to master; all other signals flow master to slave.
interface axis_demux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_demux_out_reg.sv
// Two-entry skid register (main + temp) for one demux output.
// Latency: a beat loaded at cycle k is presented with tvalid at k+1.
// Backpressure: ready_early_o says a beat may be loaded next cycle without overflow.
//
// Ports: clk/rst; load_i with tdata_i/tlast_i/tuser_i is the incoming beat;
// tdata_o/tvalid_o/tlast_o/tuser_o/tready_i is the downstream AXI-Stream side.
module axis_demux_out_reg
  import axis_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tlast_i,
  input  logic [USER_WIDTH-1:0] tuser_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic [USER_WIDTH-1:0] tuser_o,
  output logic                  ready_early_o
);

  localparam int BW = DATA_WIDTH + USER_WIDTH + 1;

  logic [BW-1:0] beat_in;
  logic          m_vld_q, m_vld_d;
  logic [BW-1:0] m_dat_q, m_dat_d;
  logic          t_vld_q, t_vld_d;
  logic [BW-1:0] t_dat_q, t_dat_d;

  assign beat_in = {tlast_i, tuser_i, tdata_i};

  always_comb begin
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    t_vld_d = t_vld_q;
    t_dat_d = t_dat_q;
    if (tready_i || !m_vld_q) begin
      // Main slot frees up this cycle. Older temp beat goes first to keep order.
      if (t_vld_q) begin
        m_vld_d = 1'b1;
        m_dat_d = t_dat_q;
        t_vld_d = load_i;
        if (load_i) begin
          t_dat_d = beat_in;
        end
      end else begin
        m_vld_d = load_i;
        if (load_i) begin
          m_dat_d = beat_in;
        end
      end
    end else if (load_i) begin
      // Main is stalled; park the beat in temp.
      t_vld_d = 1'b1;
      t_dat_d = beat_in;
    end
  end

  // Temp stays empty next cycle, so one more beat can always be absorbed.
  assign ready_early_o = !t_vld_q && (tready_i || !m_vld_q || !load_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      t_vld_q <= 1'b0;
      t_dat_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      t_vld_q <= t_vld_d;
      t_dat_q <= t_dat_d;
    end
  end

  assign tvalid_o = m_vld_q;
  assign tdata_o  = m_dat_q[DATA_WIDTH-1:0];
  assign tuser_o  = m_dat_q[DATA_WIDTH +: USER_WIDTH];
  assign tlast_o  = m_dat_q[BW-1];

endmodule

// File: rtl/axis_demux_4.sv
// 1-to-4 AXI4-Stream frame demux; destination/drop chosen once per frame, held to tlast.
// Latency: accepted beat appears on its output one cycle later; one idle input cycle per frame start.
// Backpressure: registered input tready tracks the selected skid stage; always 1 in drop mode.
//
// Ports: clk/rst (sync, active-high); input_axis slave stream; output_0..3_axis
// master streams; enable gates new frames; drop/select sampled at frame start.
module axis_demux_4
  import axis_demux_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_demux_if.slave          input_axis,
  axis_demux_if.master         output_0_axis,
  axis_demux_if.master         output_1_axis,
  axis_demux_if.master         output_2_axis,
  axis_demux_if.master         output_3_axis,
  input  logic                 enable,
  input  logic                 drop,
  input  logic [SEL_WIDTH-1:0] select
);

  demux_state_t         state_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 drop_q;
  logic                 in_rdy_q;

  logic                  accept;
  logic [USER_WIDTH-1:0] user_in;

  logic [NUM_OUTPUTS-1:0]                 load;
  logic [NUM_OUTPUTS-1:0]                 ready_early;
  logic [NUM_OUTPUTS-1:0]                 out_vld;
  logic [NUM_OUTPUTS-1:0]                 out_rdy;
  logic [NUM_OUTPUTS-1:0]                 out_last;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_dat;
  logic [NUM_OUTPUTS-1:0][USER_WIDTH-1:0] out_user;

  assign accept  = input_axis.tvalid && in_rdy_q;
  assign user_in = (USER_ENABLE != 0) ? input_axis.tuser : '0;
  assign input_axis.tready = in_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      drop_q   <= 1'b0;
      in_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (input_axis.tvalid && enable) begin
            state_q  <= BUSY;
            sel_q    <= select;
            drop_q   <= drop;
            // The chosen output may still hold a full skid from its previous frame.
            in_rdy_q <= drop || ready_early[select];
          end else begin
            in_rdy_q <= 1'b0;
          end
        end
        BUSY: begin
          if (accept && input_axis.tlast) begin
            state_q  <= IDLE;
            in_rdy_q <= 1'b0;
          end else begin
            in_rdy_q <= drop_q || ready_early[sel_q];
          end
        end
        default: begin
          state_q  <= IDLE;
          in_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
    assign load[g] = accept && !drop_q && (sel_q == SEL_WIDTH'(g));

    axis_demux_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH)
    ) u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load[g]),
      .tdata_i       (input_axis.tdata),
      .tlast_i       (input_axis.tlast),
      .tuser_i       (user_in),
      .tdata_o       (out_dat[g]),
      .tvalid_o      (out_vld[g]),
      .tready_i      (out_rdy[g]),
      .tlast_o       (out_last[g]),
      .tuser_o       (out_user[g]),
      .ready_early_o (ready_early[g])
    );
  end

  assign out_rdy[0]           = output_0_axis.tready;
  assign output_0_axis.tdata  = out_dat[0];
  assign output_0_axis.tvalid = out_vld[0];
  assign output_0_axis.tlast  = out_last[0];
  assign output_0_axis.tuser  = out_user[0];

  assign out_rdy[1]           = output_1_axis.tready;
  assign output_1_axis.tdata  = out_dat[1];
  assign output_1_axis.tvalid = out_vld[1];
  assign output_1_axis.tlast  = out_last[1];
  assign output_1_axis.tuser  = out_user[1];

  assign out_rdy[2]           = output_2_axis.tready;
  assign output_2_axis.tdata  = out_dat[2];
  assign output_2_axis.tvalid = out_vld[2];
  assign output_2_axis.tlast  = out_last[2];
  assign output_2_axis.tuser  = out_user[2];

  assign out_rdy[3]           = output_3_axis.tready;
  assign output_3_axis.tdata  = out_dat[3];
  assign output_3_axis.tvalid = out_vld[3];
  assign output_3_axis.tlast  = out_last[3];
  assign output_3_axis.tuser  = out_user[3];

endmodule
